// File: rtl/ndp_sched_pkg.sv
// rtl/ndp_sched_pkg.sv - shared types and defaults for the NDP range scheduler
package ndp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

  localparam int DEF_ENTRIES = 4;
  localparam int DEF_ADDR_W  = 64;

  function automatic int tag_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/ndp_range_overlap.sv
// rtl/ndp_range_overlap.sv - half-open range overlap test of the held request against one slot
module ndp_range_overlap #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] size,
  input  logic [ADDR_W-1:0] slot_addr,
  input  logic [ADDR_W-1:0] slot_size,
  input  logic              slot_valid,
  output logic              hit
);

  // One extra bit on the end so a range reaching the top of memory never wraps
  logic [ADDR_W:0] req_end;
  logic [ADDR_W:0] slot_end;

  assign req_end  = {1'b0, addr} + {1'b0, size};
  assign slot_end = {1'b0, slot_addr} + {1'b0, slot_size};

  assign hit = slot_valid
             && (size != '0)
             && (slot_size != '0)
             && ({1'b0, addr} < slot_end)
             && ({1'b0, slot_addr} < req_end);

endmodule

// File: rtl/ndp_range_scheduler.sv
// rtl/ndp_range_scheduler.sv - admits byte-range requests only when disjoint from all in-flight ranges
module ndp_range_scheduler
  import ndp_sched_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TAG_W   = tag_w(ENTRIES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [ADDR_W-1:0]            req_size,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [ADDR_W-1:0]            iss_addr,
  output logic [ADDR_W-1:0]            iss_size,
  output logic [TAG_W-1:0]             iss_tag,
  input  logic                         done_valid,
  input  logic [TAG_W-1:0]             done_tag,
  output logic                         conflict_stall,
  output logic [$clog2(ENTRIES+1)-1:0] inflight_cnt
);

  localparam int CNT_W = $clog2(ENTRIES+1);

  sched_state_t state, next_state;

  logic [ADDR_W-1:0]  slot_addr [ENTRIES];
  logic [ADDR_W-1:0]  slot_size [ENTRIES];
  logic [ENTRIES-1:0] slot_valid;
  logic [ENTRIES-1:0] valid_next;
  logic [ENTRIES-1:0] hits;

  logic [ADDR_W-1:0] hold_addr;
  logic [ADDR_W-1:0] hold_size;
  logic [TAG_W-1:0]  hold_tag;
  logic [TAG_W-1:0]  free_idx;
  logic [CNT_W-1:0]  cnt_next;

  logic any_hit;
  logic full;
  logic capture;
  logic alloc;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    ndp_range_overlap #(.ADDR_W(ADDR_W)) u_cmp (
      .addr      (hold_addr),
      .size      (hold_size),
      .slot_addr (slot_addr[g]),
      .slot_size (slot_size[g]),
      .slot_valid(slot_valid[g]),
      .hit       (hits[g])
    );
  end

  assign any_hit = |hits;
  assign full    = &slot_valid;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!slot_valid[i]) free_idx = TAG_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    capture    = 1'b0;
    alloc      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (req_valid) begin
          capture    = 1'b1;
          next_state = CHECK;
        end
      end
      CHECK: begin
        if (!any_hit && !full) begin
          alloc      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (iss_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The allocated slot was free during CHECK, so it never collides with a retire
  always_comb begin
    valid_next = slot_valid;
    if (done_valid) valid_next[done_tag] = 1'b0;
    if (alloc)      valid_next[free_idx] = 1'b1;
    cnt_next = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cnt_next = cnt_next + CNT_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_valid     <= '0;
      inflight_cnt   <= '0;
      conflict_stall <= 1'b0;
      hold_addr      <= '0;
      hold_size      <= '0;
      hold_tag       <= '0;
    end else begin
      slot_valid     <= valid_next;
      inflight_cnt   <= cnt_next;
      conflict_stall <= (state == CHECK) && any_hit;
      if (capture) begin
        hold_addr <= req_addr;
        hold_size <= req_size;
      end
      if (alloc) hold_tag <= free_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      slot_addr[free_idx] <= hold_addr;
      slot_size[free_idx] <= hold_size;
    end
  end

  assign iss_valid = (state == ISSUE);
  assign iss_addr  = hold_addr;
  assign iss_size  = hold_size;
  assign iss_tag   = hold_tag;

endmodule
